time_keeper: RTL

- Running real-time clock that consumes the packed time/date words produced by the time-setting controller.
- Loads a set value on LOAD, then advances once per second from an internal prescaler.
- Carries seconds → minutes → hours → meridian → day → month → year.
- Drives the same packed format back out to display and alarm logic.

---
 rtl/time_keeper_pkg.sv | 50 +++++
 rtl/time_keeper_month_len.sv | 33 +++
 rtl/time_keeper.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/time_keeper_pkg.sv
// Shared definitions for the real-time clock: packed time/date layouts,
// meridian constants, field limits and reset values.
// Pure declarations; no latency and no backpressure apply.
package time_keeper_pkg;

   // Time word: [16] meridian, [15:12] hour, [11:6] minute, [5:0] second.
   localparam int SEC_LSB   = 0;
   localparam int SEC_W     = 6;
   localparam int MIN_LSB   = 6;
   localparam int MIN_W     = 6;
   localparam int HOUR_LSB  = 12;
   localparam int HOUR_W    = 4;
   localparam int MER_BIT   = 16;

   // Date word: [16:10] year, [9:5] month, [4:0] day.
   localparam int DAY_LSB   = 0;
   localparam int DAY_W     = 5;
   localparam int MONTH_LSB = 5;
   localparam int MONTH_W   = 5;
   localparam int YEAR_LSB  = 10;
   localparam int YEAR_W    = 7;

   localparam logic MER_AM = 1'b0;
   localparam logic MER_PM = 1'b1;

   localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
   localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
   localparam logic [HOUR_W-1:0]  HOUR_MAX  = 4'd12;
   localparam logic [MONTH_W-1:0] MONTH_MAX = 5'd12;
   localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;
   localparam logic [DAY_W-1:0]   DAY_MAX   = 5'd31;

   // Field order matches the bit layout above, so a cast maps ports directly.
   typedef struct packed {
      logic              mer;
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
   } time_t;

   typedef struct packed {
      logic [YEAR_W-1:0]  year;
      logic [MONTH_W-1:0] month;
      logic [DAY_W-1:0]   day;
   } date_t;

   localparam time_t RST_TIME = '{mer: MER_AM, hour: 4'd12, min: 6'd0, sec: 6'd0};
   localparam date_t RST_DATE = '{year: 7'd0, month: 5'd1, day: 5'd1};

endpackage

// File: rtl/time_keeper_month_len.sv
// Month length lookup (month, year) -> days in month, 28..31.
// Purely combinational, zero latency; no backpressure.
// Macro CALENDAR_EN selects true month lengths with leap years; otherwise
// every month is 31 days and the inputs are ignored.
// Ports: month [4:0] (1..12), year [6:0] (0..99), days [4:0].
module time_keeper_month_len
   import time_keeper_pkg::*;
(
   input  logic [MONTH_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   output logic [DAY_W-1:0]   days
);

`ifdef CALENDAR_EN
   // Only the low two year bits decide leap years (year 0 counts as leap).
   logic unused_year_hi;
   assign unused_year_hi = ^year[YEAR_W-1:2];

   always_comb begin
      days = DAY_MAX;
      case (month)
         5'd4, 5'd6, 5'd9, 5'd11: days = 5'd30;
         5'd2:                    days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 days = DAY_MAX;
      endcase
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{month, year};
   assign days          = DAY_MAX;
`endif

endmodule

// File: rtl/time_keeper.sv
// Real-time clock: loads a packed time/date, then advances once per TICK_DIV
// cycles with full sec->min->hour->meridian->day->month->year carry.
// Latency: LOAD visible on outputs one cycle after the strobe; no backpressure,
// HOLD freezes the prescaler and all fields. Optional macro: CALENDAR_EN.
// Ports: CLK, RESETN (async active-low), LOAD (strobe), HOLD (level),
//        IN_TIME/IN_DATE (17b packed), OUT_TIME/OUT_DATE (17b packed, registered),
//        SEC_PULSE (advance strobe), DAY_PULSE (midnight strobe).
module time_keeper
   import time_keeper_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
)(
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        LOAD,
   input  logic        HOLD,
   input  logic [16:0] IN_TIME,
   input  logic [16:0] IN_DATE,
   output logic [16:0] OUT_TIME,
   output logic [16:0] OUT_DATE,
   output logic        SEC_PULSE,
   output logic        DAY_PULSE
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   time_t            cur_time, in_time, ld_time, adv_time;
   date_t            cur_date, in_date, ld_date, adv_date;
   logic [CNT_W-1:0] presc;
   logic [DAY_W-1:0] cur_len, ld_len;
   logic [MONTH_W-1:0] ld_month;
   logic [YEAR_W-1:0]  ld_year;
   logic             day_carry;

   assign in_time  = time_t'(IN_TIME);
   assign in_date  = date_t'(IN_DATE);
   assign OUT_TIME = cur_time;
   assign OUT_DATE = cur_date;

   // ---------------- load sanitization ----------------
   // Month and year are cleaned first so the day check uses the length of the
   // month that will actually be stored.
   assign ld_month = (in_date.month == '0 || in_date.month > MONTH_MAX) ? 5'd1 : in_date.month;
   assign ld_year  = (in_date.year > YEAR_MAX) ? 7'd0 : in_date.year;

   time_keeper_month_len u_ld_len (
      .month (ld_month),
      .year  (ld_year),
      .days  (ld_len)
   );

   always_comb begin
      ld_time       = in_time;
      ld_time.hour  = (in_time.hour == '0 || in_time.hour > HOUR_MAX) ? HOUR_MAX : in_time.hour;
      ld_time.min   = (in_time.min > MIN_MAX) ? 6'd0 : in_time.min;
      ld_time.sec   = (in_time.sec > SEC_MAX) ? 6'd0 : in_time.sec;
      ld_date.year  = ld_year;
      ld_date.month = ld_month;
      ld_date.day   = (in_date.day == '0 || in_date.day > ld_len) ? 5'd1 : in_date.day;
   end

   // ---------------- advance chain ----------------
   time_keeper_month_len u_cur_len (
      .month (cur_date.month),
      .year  (cur_date.year),
      .days  (cur_len)
   );

   always_comb begin
      adv_time  = cur_time;
      adv_date  = cur_date;
      day_carry = 1'b0;
      if (cur_time.sec >= SEC_MAX) begin
         adv_time.sec = '0;
         if (cur_time.min >= MIN_MAX) begin
            adv_time.min = '0;
            case (cur_time.hour)
               4'd12: adv_time.hour = 4'd1;
               4'd11: begin
                  // 11 -> 12 flips the meridian; PM -> AM is midnight.
                  adv_time.hour = 4'd12;
                  adv_time.mer  = ~cur_time.mer;
                  day_carry     = (cur_time.mer == MER_PM);
               end
               default: adv_time.hour = cur_time.hour + 4'd1;
            endcase
         end else begin
            adv_time.min = cur_time.min + 6'd1;
         end
      end else begin
         adv_time.sec = cur_time.sec + 6'd1;
      end

      if (day_carry) begin
         if (cur_date.day >= cur_len) begin
            adv_date.day = 5'd1;
            if (cur_date.month >= MONTH_MAX) begin
               adv_date.month = 5'd1;
               adv_date.year  = (cur_date.year >= YEAR_MAX) ? 7'd0 : cur_date.year + 7'd1;
            end else begin
               adv_date.month = cur_date.month + 5'd1;
            end
         end else begin
            adv_date.day = cur_date.day + 5'd1;
         end
      end
   end

   // ---------------- state ----------------
   // LOAD wins over an advance that would otherwise happen in the same cycle.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cur_time  <= RST_TIME;
         cur_date  <= RST_DATE;
         presc     <= '0;
         SEC_PULSE <= 1'b0;
         DAY_PULSE <= 1'b0;
      end else begin
         SEC_PULSE <= 1'b0;
         DAY_PULSE <= 1'b0;
         if (LOAD) begin
            cur_time <= ld_time;
            cur_date <= ld_date;
            presc    <= '0;
         end else if (!HOLD) begin
            if (presc == TERM) begin
               presc     <= '0;
               cur_time  <= adv_time;
               cur_date  <= adv_date;
               SEC_PULSE <= 1'b1;
               DAY_PULSE <= day_carry;
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

endmodule
